// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared row geometry, status bit map and element packing helpers
package matrix_pkg;

    localparam int DATA_W  = 8;
    localparam int ROW_LEN = 28;
    localparam int BUS_W   = 32;
    localparam int WORDS   = ROW_LEN * DATA_W / BUS_W;
    localparam int VEC_W   = ROW_LEN * DATA_W;
    localparam int ADDR_W  = $clog2(WORDS);
    localparam int CNT_W   = 4;

    // prdata status layout
    localparam int ST_CNT_LSB   = 0;
    localparam int ST_A_LOADED  = 4;
    localparam int ST_ACT_VALID = 5;
    localparam int ST_STG_FULL  = 6;

    function automatic logic [DATA_W-1:0] get_elem(input logic [VEC_W-1:0] row, input int idx);
        return row[idx*DATA_W +: DATA_W];
    endfunction

    // Word k carries elements 4k..4k+3 with the lowest index in the low byte
    function automatic logic [VEC_W-1:0] put_word(input logic [VEC_W-1:0] row, input int k,
                                                  input logic [BUS_W-1:0] w);
        logic [VEC_W-1:0] r;
        r = row;
        r[k*BUS_W +: BUS_W] = w;
        return r;
    endfunction

endpackage

// File: rtl/row_buf.sv
// rtl/row_buf.sv - word-addressed row register with parallel load and parallel row output
module row_buf
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic              ld_en,
    input  logic [VEC_W-1:0]  ld_row,
    output logic [VEC_W-1:0]  row
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
        end else if (ld_en) begin
            row <= ld_row;
        end else if (wr_en) begin
            for (int k = 0; k < WORDS; k++) begin
                if (wr_addr == ADDR_W'(k))
                    row[k*BUS_W +: BUS_W] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/apb_row_loader.sv
// rtl/apb_row_loader.sv - APB write slave assembling coefficient row A and double-buffered X rows
module apb_row_loader
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [BUS_W-1:0] pwdata,
    output logic [BUS_W-1:0] prdata,
    output logic             pready,
    output logic             pslverr,
    input  logic             ctrl_pready,
    input  logic             load_en,
    input  logic             load_A_en,
    input  logic             row_finish,
    output logic             load_A_done,
    output logic             load_done,
    output logic [VEC_W-1:0] a_vec,
    output logic [VEC_W-1:0] x_vec
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic             a_loaded;
    logic             stg_full;
    logic             act_valid;
    logic             a_phase_q;
    logic             load_A_done_q;
    logic             load_done_q;

    logic             xfer;
    logic             wr_ok;
    logic             phase_chg;
    logic             at_last;
    logic             a_wr;
    logic             x_wr;
    logic             a_last;
    logic             x_last;
    logic             rf;
    logic             copy;
    logic [VEC_W-1:0] stg_row;
    logic [VEC_W-1:0] merged;

    assign pready = ctrl_pready & ~stg_full;

    always_comb begin
        xfer      = psel & penable & pready;
        wr_ok     = xfer & pwrite & load_en;
        pslverr   = xfer & pwrite & ~load_en;
        // Any switch between A and X phase discards a partially assembled row
        phase_chg = (load_A_en != a_phase_q);
        cnt_eff   = phase_chg ? '0 : word_cnt;
        at_last   = (cnt_eff == LAST_CNT);
        a_wr      = wr_ok & load_A_en;
        x_wr      = wr_ok & ~load_A_en;
        a_last    = a_wr & at_last;
        x_last    = x_wr & at_last;
        // Keeps load_done from coinciding with load_A_done
        rf        = load_en & row_finish & ~a_last;
        copy      = (x_last & (~act_valid | rf)) | (stg_full & rf);
        // The final word is still in flight, so fold it into the copied row
        merged    = x_last ? put_word(stg_row, WORDS - 1, pwdata) : stg_row;
    end

    always_comb begin
        prdata                          = '0;
        prdata[ST_CNT_LSB +: CNT_W]     = word_cnt;
        prdata[ST_A_LOADED]             = a_loaded;
        prdata[ST_ACT_VALID]            = act_valid;
        prdata[ST_STG_FULL]             = stg_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt      <= '0;
            a_loaded      <= 1'b0;
            stg_full      <= 1'b0;
            act_valid     <= 1'b0;
            a_phase_q     <= 1'b0;
            load_A_done_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            a_phase_q     <= load_A_en;
            load_A_done_q <= a_last;
            load_done_q   <= copy;
            if (!load_en) begin
                word_cnt  <= '0;
                a_loaded  <= 1'b0;
                stg_full  <= 1'b0;
                act_valid <= 1'b0;
            end else begin
                if (wr_ok)
                    word_cnt <= at_last ? '0 : cnt_eff + 1'b1;
                else
                    word_cnt <= cnt_eff;
                if (a_last)
                    a_loaded <= 1'b1;
                if (copy)
                    act_valid <= 1'b1;
                else if (rf)
                    act_valid <= 1'b0;
                if (copy)
                    stg_full <= 1'b0;
                else if (x_last)
                    stg_full <= 1'b1;
            end
        end
    end

    assign load_A_done = load_A_done_q;
    assign load_done   = load_done_q;

    row_buf u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_wr),
        .wr_addr (cnt_eff[ADDR_W-1:0]),
        .wr_data (pwdata),
        .ld_en   (1'b0),
        .ld_row  ('0),
        .row     (a_vec)
    );

    row_buf u_stg_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (x_wr),
        .wr_addr (cnt_eff[ADDR_W-1:0]),
        .wr_data (pwdata),
        .ld_en   (1'b0),
        .ld_row  ('0),
        .row     (stg_row)
    );

    row_buf u_act_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data ('0),
        .ld_en   (copy),
        .ld_row  (merged),
        .row     (x_vec)
    );

endmodule

// File: tb/tb_apb_row_loader.sv
// tb/tb_apb_row_loader.sv - directed self-checking bench for apb_row_loader
module tb_apb_row_loader;
    import matrix_pkg::*;

    logic             clk;
    logic             rst;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [BUS_W-1:0] pwdata;
    logic [BUS_W-1:0] prdata;
    logic             pready;
    logic             pslverr;
    logic             ctrl_pready;
    logic             load_en;
    logic             load_A_en;
    logic             row_finish;
    logic             load_A_done;
    logic             load_done;
    logic [VEC_W-1:0] a_vec;
    logic [VEC_W-1:0] x_vec;

    int checks;
    int fails;
    logic saw_stall;

    logic [VEC_W-1:0] a_row;
    logic [VEC_W-1:0] row1;
    logic [VEC_W-1:0] row2;
    logic [VEC_W-1:0] row3;
    logic [VEC_W-1:0] row4;

    apb_row_loader dut (
        .clk         (clk),
        .rst         (rst),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .ctrl_pready (ctrl_pready),
        .load_en     (load_en),
        .load_A_en   (load_A_en),
        .row_finish  (row_finish),
        .load_A_done (load_A_done),
        .load_done   (load_done),
        .a_vec       (a_vec),
        .x_vec       (x_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] mkrow(input int base);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < ROW_LEN; i++)
            v[i*DATA_W +: DATA_W] = 8'(base + i);
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] word_of(input logic [VEC_W-1:0] r, input int k);
        return r[k*BUS_W +: BUS_W];
    endfunction

    task automatic apb_write(input logic [BUS_W-1:0] d, input logic rf, output logic err);
        int n;
        logic done;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; row_finish = rf;
        done = 1'b0; err = 1'b0; n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            if (pready) begin
                done = 1'b1;
                err  = pslverr;
            end else begin
                saw_stall = 1'b1;
            end
            n++;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; row_finish = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL write_timeout: pready stayed %b, required 1 within 50 cycles", pready);
        end
    endtask

    task automatic write_row(input logic [VEC_W-1:0] r, input int nwords);
        logic e;
        for (int k = 0; k < nwords; k++)
            apb_write(word_of(r, k), 1'b0, e);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_vec !== '0) begin fails++; $display("FAIL reset_a_vec: got %h required 0", a_vec); end
        checks++; if (x_vec !== '0) begin fails++; $display("FAIL reset_x_vec: got %h required 0", x_vec); end
        checks++; if (prdata !== 32'h0) begin fails++; $display("FAIL reset_status: got %h required 0", prdata); end
        checks++; if ({load_done, load_A_done, pslverr} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b required 000", {load_done, load_A_done, pslverr}); end
        checks++; if (pready !== 1'b1) begin fails++; $display("FAIL reset_pready: got %b required 1", pready); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_a_load;
        load_en = 1'b1; load_A_en = 1'b1;
        @(posedge clk); #1;
        write_row(a_row, WORDS);
        @(negedge clk);
        checks++; if (load_A_done !== 1'b1) begin fails++; $display("FAIL a_done_pulse: got %b required 1", load_A_done); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL a_no_load_done: got %b required 0", load_done); end
        checks++; if (a_vec !== a_row) begin fails++; $display("FAIL a_vec: got %h required %h", a_vec, a_row); end
        checks++; if (prdata !== 32'h10) begin fails++; $display("FAIL a_status: got %h required 10", prdata); end
        @(negedge clk);
        checks++; if (load_A_done !== 1'b0) begin fails++; $display("FAIL a_done_width: got %b required 0", load_A_done); end
    endtask

    task automatic test_first_row;
        logic e;
        load_A_en = 1'b0;
        @(posedge clk); #1;
        saw_stall = 1'b0;
        apb_write(word_of(row1, 0), 1'b0, e);
        checks++; if (e !== 1'b0) begin fails++; $display("FAIL x1_slverr: got %b required 0", e); end
        for (int k = 1; k < WORDS; k++)
            apb_write(word_of(row1, k), 1'b0, e);
        @(negedge clk);
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL x1_load_done: got %b required 1", load_done); end
        checks++; if (x_vec !== row1) begin fails++; $display("FAIL x1_vec: got %h required %h", x_vec, row1); end
        checks++; if (prdata !== 32'h30) begin fails++; $display("FAIL x1_status: got %h required 30", prdata); end
        checks++; if (saw_stall !== 1'b0) begin fails++; $display("FAIL x1_no_stall: got %b required 0", saw_stall); end
        @(negedge clk);
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL x1_done_width: got %b required 0", load_done); end
    endtask

    task automatic test_backpressure;
        write_row(row2, WORDS);
        @(negedge clk);
        checks++; if (pready !== 1'b0) begin fails++; $display("FAIL bp_pready_low: got %b required 0", pready); end
        checks++; if (prdata !== 32'h70) begin fails++; $display("FAIL bp_status_full: got %h required 70", prdata); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL bp_no_load_done: got %b required 0", load_done); end
        checks++; if (x_vec !== row1) begin fails++; $display("FAIL bp_x_held: got %h required %h", x_vec, row1); end
        row_finish = 1'b1;
        @(posedge clk); #1;
        row_finish = 1'b0;
        @(negedge clk);
        checks++; if (x_vec !== row2) begin fails++; $display("FAIL bp_x_copied: got %h required %h", x_vec, row2); end
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL bp_load_done: got %b required 1", load_done); end
        checks++; if (pready !== 1'b1) begin fails++; $display("FAIL bp_pready_back: got %b required 1", pready); end
        checks++; if (prdata !== 32'h30) begin fails++; $display("FAIL bp_status_after: got %h required 30", prdata); end
    endtask

    task automatic test_simultaneous;
        logic e;
        write_row(row3, WORDS - 1);
        apb_write(word_of(row3, WORDS - 1), 1'b1, e);
        @(negedge clk);
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL sim_load_done: got %b required 1", load_done); end
        checks++; if (x_vec !== row3) begin fails++; $display("FAIL sim_x_vec: got %h required %h", x_vec, row3); end
        checks++; if (prdata !== 32'h30) begin fails++; $display("FAIL sim_status: got %h required 30", prdata); end
        checks++; if (pready !== 1'b1) begin fails++; $display("FAIL sim_no_stall: got %b required 1", pready); end
    endtask

    task automatic test_slverr;
        logic e;
        load_en = 1'b0;
        @(posedge clk); #1;
        apb_write(32'hDEADBEEF, 1'b0, e);
        checks++; if (e !== 1'b1) begin fails++; $display("FAIL err_pslverr: got %b required 1", e); end
        @(negedge clk);
        checks++; if (prdata !== 32'h0) begin fails++; $display("FAIL err_status: got %h required 0", prdata); end
        checks++; if (x_vec !== row3) begin fails++; $display("FAIL err_x_kept: got %h required %h", x_vec, row3); end
        checks++; if (a_vec !== a_row) begin fails++; $display("FAIL err_a_kept: got %h required %h", a_vec, a_row); end
        ctrl_pready = 1'b0;
        #1;
        checks++; if (pready !== 1'b0) begin fails++; $display("FAIL ctrl_pready_gate: got %b required 0", pready); end
        ctrl_pready = 1'b1;
    endtask

    task automatic test_reset_mid_row;
        load_en = 1'b1; load_A_en = 1'b0;
        @(posedge clk); #1;
        write_row(row4, 3);
        @(negedge clk);
        checks++; if (prdata !== 32'h03) begin fails++; $display("FAIL mid_cnt: got %h required 03", prdata); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (prdata !== 32'h0) begin fails++; $display("FAIL mid_rst_status: got %h required 0", prdata); end
        checks++; if (a_vec !== '0) begin fails++; $display("FAIL mid_rst_a: got %h required 0", a_vec); end
        checks++; if (x_vec !== '0) begin fails++; $display("FAIL mid_rst_x: got %h required 0", x_vec); end
        @(posedge clk); #1;
        rst = 1'b1;
        write_row(row4, WORDS - 1);
        @(negedge clk);
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL mid_early_done: got %b required 0", load_done); end
        checks++; if (prdata !== 32'h06) begin fails++; $display("FAIL mid_cnt6: got %h required 06", prdata); end
        write_row(put_word('0, 0, word_of(row4, WORDS - 1)), 1);
        @(negedge clk);
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL mid_load_done: got %b required 1", load_done); end
        checks++; if (x_vec !== row4) begin fails++; $display("FAIL mid_x_vec: got %h required %h", x_vec, row4); end
        checks++; if (prdata !== 32'h20) begin fails++; $display("FAIL mid_status: got %h required 20", prdata); end
    endtask

    initial begin
        checks = 0; fails = 0; saw_stall = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        ctrl_pready = 1'b1; load_en = 1'b0; load_A_en = 1'b0; row_finish = 1'b0;
        rst = 1'b0;
        a_row = mkrow(8'h00);
        row1  = mkrow(8'h40);
        row2  = mkrow(8'h80);
        row3  = mkrow(8'hC0);
        row4  = mkrow(8'h20);
        test_reset;
        test_a_load;
        test_first_row;
        test_backpressure;
        test_simultaneous;
        test_slverr;
        test_reset_mid_row;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_row_loader.md
Name: apb_row_loader

Overview:
- APB write-slave stage directly upstream of the matrix controller/ALU.
- Assembles the coefficient row A and successive input data rows X from 32-bit APB writes.
- Generates the load_A_done and load_done pulses the controller sequences on.
- Double-buffers X: the next row fills a staging buffer while the ALU consumes the active row. APB is stalled only when staging is full and the active row is still in use.

Parameters:
- DATA_W, 8: element width in bits.
- ROW_LEN, 28: elements per row. Matches the controller's 28-cycle row.
- BUS_W, 32: APB data width. ROW_LEN*DATA_W must be a multiple of BUS_W.
- WORDS (localparam), ROW_LEN*DATA_W/BUS_W = 7: APB words per row.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write (1) / read (0).
- pwdata  in  BUS_W  APB write data.
- prdata  out  BUS_W  APB read data (status).
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- ctrl_pready  in  1  controller ready. Low during its last-row phase.
- load_en  in  1  controller: load phase active (not IDLE).
- load_A_en  in  1  controller: coefficient load phase.
- row_finish  in  1  controller: active row fully consumed this cycle.
- load_A_done  out  1  one-cycle pulse: A complete.
- load_done  out  1  one-cycle pulse: new X row is in the active buffer.
- a_vec  out  ROW_LEN*DATA_W  coefficient row. Element i at bits [i*DATA_W +: DATA_W].
- x_vec  out  ROW_LEN*DATA_W  active data row, same packing.

Behaviour:
- Transfer definition: a transfer completes on any cycle with psel & penable & pready. A write is a completed transfer with pwrite=1.
- Packing: word k, byte j (pwdata[8j+:8]) goes to element 4k+j. Byte 0 is the lowest element index.
- pready = ctrl_pready & ~stg_full. Combinational; no extra wait states otherwise.
- Write while load_en=0: no state change, pslverr=1 on that transfer. pslverr=0 in all other cases.
- Reads: no side effects. prdata = {zeros, stg_full, act_valid, a_loaded, word_cnt[3:0]}.
- Internal state: word_cnt (0..WORDS-1), a_loaded, stg_full, act_valid.
- Reset values: all internal state 0; a_vec, x_vec and the staging buffer 0; load_A_done=0, load_done=0, pslverr=0.
- A phase (load_A_en=1):
  - Each write stores word word_cnt into a_vec and increments word_cnt.
  - On the write with word_cnt=WORDS-1: word_cnt wraps to 0, a_loaded is set, and load_A_done pulses on the next cycle (registered, 1 cycle).
  - Further writes in this phase overwrite A from word 0.
- X phase (load_en=1, load_A_en=0):
  - Writes fill the staging buffer at word_cnt.
  - On the last word (word_cnt=WORDS-1), word_cnt wraps to 0 and one of the following applies:
    - act_valid=0 or row_finish=1 in the same cycle: staging is copied to x_vec, act_valid=1, and load_done pulses next cycle.
    - Otherwise: stg_full=1, which stalls APB.
  - While stg_full=1, the first row_finish copies staging to x_vec, clears stg_full and pulses load_done next cycle. act_valid stays 1.
  - row_finish with no pending copy clears act_valid.
- Simultaneous last write and row_finish: the copy takes priority and act_valid stays 1.
- load_en falling to 0 (controller IDLE): word_cnt, stg_full, act_valid and a_loaded are cleared synchronously. a_vec and x_vec retain their values.
- Phase switch mid-row (load_A_en 1→0 with word_cnt≠0): word_cnt resets to 0 and the partial row is discarded.
- Async reset mid-transfer aborts the transfer. The master must retry.
- load_done and load_A_done are never asserted in the same cycle, and never in consecutive cycles for the same row.

Decomposition:
- Shared package (matrix_pkg): DATA_W, ROW_LEN, BUS_W, WORDS, the status bit positions of prdata, and the element packing function. Common with controller/ALU.
- One natural sub-module: row_buf, a WORDS x BUS_W word-addressed register with a parallel row output. Instantiated for A, staging and active (active is loaded in parallel from staging).

Test Plan:
- Reset then A load: load_en=1, load_A_en=1, write 0x03020100 … 0x1B1A1918 (7 words). Expect load_A_done single pulse one cycle after the 7th write, and a_vec element i = i.
- First X row: load_A_en=0, write 7 words. Expect load_done pulse, x_vec updated, act_valid=1, pready never low.
- Backpressure: second row of 7 words with row_finish held low. After the 7th write expect pready=0 and stg_full=1. Pulse row_finish → x_vec takes the new row, load_done pulses next cycle, pready returns to 1.
- Simultaneous: 7th write of row 3 coincides with row_finish. Expect immediate copy, no stall, act_valid=1.
- Write with load_en=0 → pslverr=1 and no state change. ctrl_pready=0 → pready=0 regardless of buffer state.
- Assert rst low after 3 words of a row → word_cnt, status bits, a_vec and x_vec all 0. Next row requires a full 7 words before load_done.
